// File: rtl/round_ctrl.sv
// Round-sequencing controller: steps a round counter by UNROLL per cycle, up or down.
// Define ROUND_CTRL_STALL_EN to honour stl; otherwise stl is accepted but ignored.
module round_ctrl #(
  parameter  int NR     = 32,
  parameter  int UNROLL = 1,
  localparam int CW     = $clog2(NR)
) (
  input  logic          ck,
  input  logic          rst,
  input  logic          sta,
  input  logic          dec,
  input  logic          abt,
  input  logic          stl,
  output logic [CW-1:0] cnt,
  output logic          fst,
  output logic          lst,
  output logic          act,
  output logic          dir,
  output logic          rdy
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  localparam logic [CW-1:0] HIGH_IDX = CW'(NR - UNROLL);
  localparam logic [CW-1:0] STEP     = CW'(UNROLL);

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic          r_dir;
  logic          r_rdy;
  logic          w_fst;
  logic          w_lst;
  logic          w_stall;

  // Start of an up-count is 0 and its end is HIGH_IDX; a down-count swaps them.
  assign w_fst = r_dir ? (r_cnt == HIGH_IDX) : (r_cnt == '0);
  assign w_lst = r_dir ? (r_cnt == '0) : (r_cnt == HIGH_IDX);

`ifdef ROUND_CTRL_STALL_EN
  assign w_stall = stl;
`else
  logic w_unused_stl;
  assign w_unused_stl = stl;
  assign w_stall      = 1'b0;
`endif

  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_dir   <= 1'b0;
      r_rdy   <= 1'b0;
    end else if (sta) begin
      // A start always wins, so a coinciding completion never raises rdy.
      r_state <= RUN;
      r_dir   <= dec;
      r_cnt   <= dec ? HIGH_IDX : '0;
      r_rdy   <= 1'b0;
    end else if (abt) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_rdy   <= 1'b0;
    end else if (r_state == RUN) begin
      if (w_stall) begin
        r_rdy <= 1'b0;
      end else if (w_lst) begin
        r_state <= IDLE;
        r_cnt   <= '0;
        r_rdy   <= 1'b1;
      end else begin
        r_cnt <= r_dir ? (r_cnt - STEP) : (r_cnt + STEP);
        r_rdy <= 1'b0;
      end
    end else begin
      r_rdy <= 1'b0;
    end
  end

  assign cnt = r_cnt;
  assign fst = w_fst;
  assign lst = w_lst;
  assign act = (r_state == RUN);
  assign dir = r_dir;
  assign rdy = r_rdy;

endmodule

// File: tb/tb_round_ctrl.sv
// Directed bench for round_ctrl: one NR=32/UNROLL=1 instance and one NR=32/UNROLL=4 instance.
// Stall expectations follow whether ROUND_CTRL_STALL_EN is defined for the build.
module tb_round_ctrl;

  logic       ck;
  logic       rst;
  logic       sta1, dec1, abt1, stl1;
  logic [4:0] cnt1;
  logic       fst1, lst1, act1, dir1, rdy1;
  logic       sta4, dec4, abt4, stl4;
  logic [4:0] cnt4;
  logic       fst4, lst4, act4, dir4, rdy4;

  int n_cmp = 0;
  int n_err = 0;

  round_ctrl #(.NR(32), .UNROLL(1)) u_dut1 (
    .ck(ck), .rst(rst), .sta(sta1), .dec(dec1), .abt(abt1), .stl(stl1),
    .cnt(cnt1), .fst(fst1), .lst(lst1), .act(act1), .dir(dir1), .rdy(rdy1)
  );

  round_ctrl #(.NR(32), .UNROLL(4)) u_dut4 (
    .ck(ck), .rst(rst), .sta(sta4), .dec(dec4), .abt(abt4), .stl(stl4),
    .cnt(cnt4), .fst(fst4), .lst(lst4), .act(act4), .dir(dir4), .rdy(rdy4)
  );

  initial begin
    ck = 1'b0;
    forever #5 ck = ~ck;
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge ck);
    #1;
  endtask

  int n_wait;
  int n_rdy;
  int exp_lat;

  initial begin
    rst = 1'b1;
    {sta1, dec1, abt1, stl1} = '0;
    {sta4, dec4, abt4, stl4} = '0;
    repeat (2) @(posedge ck);
    #1;
    rst = 1'b0;

    // Reset state
    chk("rst_cnt", cnt1, 0);
    chk("rst_act", act1, 0);
    chk("rst_dir", dir1, 0);
    chk("rst_rdy", rdy1, 0);
    chk("rst_fst", fst1, 1);
    chk("rst_lst", lst1, 0);
    $display("reset state checked");

    // Encrypt run, UNROLL=1
    sta1 = 1'b1; dec1 = 1'b0;
    tick();
    sta1 = 1'b0;
    for (int i = 0; i < 32; i++) begin
      chk("up_cnt", cnt1, i);
      chk("up_act", act1, 1);
      chk("up_fst", fst1, (i == 0) ? 1 : 0);
      chk("up_lst", lst1, (i == 31) ? 1 : 0);
      chk("up_rdy", rdy1, 0);
      tick();
    end
    chk("up_rdy_pulse", rdy1, 1);
    chk("up_done_act", act1, 0);
    chk("up_done_cnt", cnt1, 0);
    tick();
    chk("up_rdy_drop", rdy1, 0);
    $display("encrypt run UNROLL=1 checked");

    // Decrypt run, UNROLL=4
    sta4 = 1'b1; dec4 = 1'b1;
    tick();
    sta4 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("dn4_cnt", cnt4, 28 - 4 * i);
      chk("dn4_act", act4, 1);
      chk("dn4_dir", dir4, 1);
      chk("dn4_fst", fst4, (i == 0) ? 1 : 0);
      chk("dn4_lst", lst4, (i == 7) ? 1 : 0);
      tick();
    end
    chk("dn4_rdy_pulse", rdy4, 1);
    chk("dn4_done_cnt", cnt4, 0);
    tick();
    chk("dn4_rdy_drop", rdy4, 0);
    $display("decrypt run UNROLL=4 checked");

    // Stall for three cycles at cnt=10
    sta1 = 1'b1; dec1 = 1'b0;
    tick();
    sta1 = 1'b0;
    repeat (10) tick();
    chk("stl_pre_cnt", cnt1, 10);
    stl1 = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tick();
`ifdef ROUND_CTRL_STALL_EN
      chk("stl_hold_cnt", cnt1, 10);
`else
      chk("stl_ign_cnt", cnt1, 10 + i);
`endif
      chk("stl_act", act1, 1);
    end
    stl1 = 1'b0;
    n_wait = 13;
    while (rdy1 !== 1'b1 && n_wait < 80) begin
      tick();
      n_wait++;
    end
`ifdef ROUND_CTRL_STALL_EN
    exp_lat = 35;
`else
    exp_lat = 32;
`endif
    chk("stl_rdy_latency", n_wait, exp_lat);
    tick();
    chk("stl_rdy_drop", rdy1, 0);
    $display("stall scenario checked, rdy after %0d edges", n_wait);

    // Abort at cnt=17
    sta1 = 1'b1; dec1 = 1'b0;
    tick();
    sta1 = 1'b0;
    repeat (17) tick();
    chk("abt_pre_cnt", cnt1, 17);
    abt1 = 1'b1;
    tick();
    abt1 = 1'b0;
    chk("abt_act", act1, 0);
    chk("abt_cnt", cnt1, 0);
    chk("abt_rdy", rdy1, 0);
    n_rdy = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (rdy1) n_rdy++;
    end
    chk("abt_no_rdy", n_rdy, 0);
    $display("abort scenario checked");

    // Start in the lst cycle: restart, no rdy
    sta1 = 1'b1; dec1 = 1'b0;
    tick();
    sta1 = 1'b0;
    repeat (31) tick();
    chk("rs_lst", lst1, 1);
    sta1 = 1'b1;
    tick();
    sta1 = 1'b0;
    chk("rs_act", act1, 1);
    chk("rs_cnt", cnt1, 0);
    chk("rs_rdy", rdy1, 0);
    tick();
    chk("rs_rdy_next", rdy1, 0);
    chk("rs_cnt_next", cnt1, 1);

    // sta and abt together act as a start
    sta1 = 1'b1; abt1 = 1'b1; dec1 = 1'b1;
    tick();
    sta1 = 1'b0; abt1 = 1'b0;
    chk("sa_act", act1, 1);
    chk("sa_cnt", cnt1, 31);
    chk("sa_dir", dir1, 1);
    repeat (32) tick();
    chk("sa_rdy", rdy1, 1);

    // Start in the rdy cycle: no gap
    sta1 = 1'b1; dec1 = 1'b1;
    tick();
    sta1 = 1'b0;
    chk("b2b_act", act1, 1);
    chk("b2b_cnt", cnt1, 31);
    chk("b2b_rdy", rdy1, 0);
    $display("simultaneous-event scenarios checked");

    // Asynchronous reset between edges at cnt=20
    repeat (11) tick();
    chk("ar_pre_cnt", cnt1, 20);
    #2;
    rst = 1'b1;
    #1;
    chk("ar_cnt", cnt1, 0);
    chk("ar_act", act1, 0);
    chk("ar_dir", dir1, 0);
    chk("ar_rdy", rdy1, 0);
    #2;
    rst = 1'b0;
    tick();
    sta1 = 1'b1; dec1 = 1'b0;
    tick();
    sta1 = 1'b0;
    chk("ar_run_act", act1, 1);
    chk("ar_run_cnt0", cnt1, 0);
    tick();
    chk("ar_run_cnt1", cnt1, 1);
    $display("async reset scenario checked");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
